gpio_cfg_ctrl: RTL and testbench

//  Access controller for the GPIO configuration register bank. Turns a CPU req/ack

---
 rtl/gpio_cfg_pkg.sv | 15 +
 rtl/gpio_cfg_clr_seq.sv | 40 ++++
 rtl/gpio_cfg_ctrl.sv | 159 +++++++++++++++
 tb/tb_gpio_cfg_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared types and default sizes for the GPIO configuration access controller.
package gpio_cfg_pkg;

    localparam int unsigned DW_DEF   = 8;
    localparam int unsigned NREG_DEF = 6;
    localparam int unsigned AW_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACK  = 2'd2,
        CLR  = 2'd3
    } state_e;

endpackage

// File: rtl/gpio_cfg_clr_seq.sv
// Soft-clear sweep: walks a one-hot clear strobe across the register bank, one per cycle.
module gpio_cfg_clr_seq
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            active,
    output logic            done_c,
    output logic [NREG-1:0] clr
);

    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [IW-1:0] idx;

    // Last register of the sweep is being cleared this cycle.
    assign done_c = active && (idx == IW'(NREG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            clr <= '0;
        end else if (start) begin
            idx <= '0;
            clr <= NREG'(1);
        end else if (active) begin
            if (done_c) begin
                idx <= '0;
                clr <= '0;
            end else begin
                idx <= idx + IW'(1);
                clr <= clr << 1;
            end
        end
    end

endmodule

// File: rtl/gpio_cfg_ctrl.sv
// CPU req/ack access controller and soft-clear arbiter for the GPIO config register bank.
// Optional GPIO_CFG_CTRL_ERR_EN adds cpu_err_o, flagging out-of-range accesses.
module gpio_cfg_ctrl
    import gpio_cfg_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req_i,
    input  logic               cpu_we_i,
    input  logic [AW-1:0]      cpu_addr_i,
    input  logic [DW-1:0]      cpu_wdata_i,
    output logic [DW-1:0]      cpu_rdata_o,
    output logic               cpu_ack_o,
    input  logic               swclr_i,
    output logic               clr_busy_o,
    output logic [NREG-1:0]    reg_wen_o,
    output logic [NREG-1:0]    reg_ren_o,
    output logic [DW-1:0]      reg_di_o,
    output logic [NREG-1:0]    reg_clr_o,
    input  logic [NREG*DW-1:0] reg_q_i
`ifdef GPIO_CFG_CTRL_ERR_EN
    ,
    output logic               cpu_err_o
`endif
);

    state_e          state, state_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic            we_q, we_n;
    logic            pending, pending_n;
    logic            ack_n;
    logic [DW-1:0]   rdata_n;
    logic [NREG-1:0] wen_n, ren_n;
    logic [DW-1:0]   di_n;
    logic            clr_start_c;
    logic            clr_done_c;
    logic [NREG-1:0] sel_c;
    logic [DW-1:0]   rd_c;
    logic            oor_q_c;
`ifdef GPIO_CFG_CTRL_ERR_EN
    logic            err_n;
`endif

    // Decode of the live request address and read mux on the captured address.
    always_comb begin
        sel_c = '0;
        rd_c  = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (cpu_addr_i == AW'(i)) sel_c[i] = 1'b1;
            if (addr_q == AW'(i))     rd_c     = reg_q_i[i*DW +: DW];
        end
    end

    assign oor_q_c = (32'(addr_q) >= NREG);

    // Next state and next registered outputs; outputs line up with the state they belong to.
    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        we_n        = we_q;
        pending_n   = pending | swclr_i;
        ack_n       = 1'b0;
        rdata_n     = '0;
        wen_n       = '0;
        ren_n       = '0;
        di_n        = '0;
        clr_start_c = 1'b0;
`ifdef GPIO_CFG_CTRL_ERR_EN
        err_n       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pending || swclr_i) begin
                    state_n     = CLR;
                    clr_start_c = 1'b1;
                end else if (cpu_req_i) begin
                    state_n = ACC;
                    addr_n  = cpu_addr_i;
                    we_n    = cpu_we_i;
                    if (cpu_we_i) begin
                        wen_n = sel_c;
                        di_n  = cpu_wdata_i;
                    end else begin
                        ren_n = sel_c;
                    end
                end
            end
            ACC: begin
                state_n = ACK;
                ack_n   = 1'b1;
                if (!we_q) rdata_n = rd_c;
`ifdef GPIO_CFG_CTRL_ERR_EN
                err_n   = oor_q_c;
`endif
            end
            ACK: begin
                state_n = IDLE;
            end
            CLR: begin
                // Requests arriving mid-sweep merge into the sweep in progress.
                if (clr_done_c) begin
                    state_n   = IDLE;
                    pending_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            pending     <= 1'b0;
            cpu_ack_o   <= 1'b0;
            cpu_rdata_o <= '0;
            clr_busy_o  <= 1'b0;
            reg_wen_o   <= '0;
            reg_ren_o   <= '0;
            reg_di_o    <= '0;
`ifdef GPIO_CFG_CTRL_ERR_EN
            cpu_err_o   <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            addr_q      <= addr_n;
            we_q        <= we_n;
            pending     <= pending_n;
            cpu_ack_o   <= ack_n;
            cpu_rdata_o <= rdata_n;
            clr_busy_o  <= pending_n;
            reg_wen_o   <= wen_n;
            reg_ren_o   <= ren_n;
            reg_di_o    <= di_n;
`ifdef GPIO_CFG_CTRL_ERR_EN
            cpu_err_o   <= err_n;
`endif
        end
    end

    gpio_cfg_clr_seq #(
        .NREG (NREG)
    ) u_clr_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (clr_start_c),
        .active (state == CLR),
        .done_c (clr_done_c),
        .clr    (reg_clr_o)
    );

endmodule

// File: tb/tb_gpio_cfg_ctrl.sv
// Self-checking bench for gpio_cfg_ctrl: scoreboarded CPU accesses, clear sweeps and resets.
module tb_gpio_cfg_ctrl;
    import gpio_cfg_pkg::*;

    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 6;
    localparam int unsigned AW   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               req, we, swclr;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      wdata;
    logic [DW-1:0]      rdata;
    logic               ack, busy;
    logic [NREG-1:0]    wen, ren, clr;
    logic [DW-1:0]      di;
    logic [NREG*DW-1:0] reg_q;
    logic [DW-1:0]      bank [NREG];
`ifdef GPIO_CFG_CTRL_ERR_EN
    logic               err;
`endif

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < int'(NREG); g++) begin : g_pack
        assign reg_q[g*DW +: DW] = bank[g];
    end

    gpio_cfg_ctrl #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (req),
        .cpu_we_i    (we),
        .cpu_addr_i  (addr),
        .cpu_wdata_i (wdata),
        .cpu_rdata_o (rdata),
        .cpu_ack_o   (ack),
        .swclr_i     (swclr),
        .clr_busy_o  (busy),
        .reg_wen_o   (wen),
        .reg_ren_o   (ren),
        .reg_di_o    (di),
        .reg_clr_o   (clr),
        .reg_q_i     (reg_q)
`ifdef GPIO_CFG_CTRL_ERR_EN
        ,
        .cpu_err_o   (err)
`endif
    );

    // One CPU access; optional same-cycle soft clear, optional soft clear pulsed in the ack cycle.
    task automatic do_access(input logic a_we, input logic [AW-1:0] a_addr,
                             input logic [DW-1:0] a_wdata, input bit with_clr,
                             input bit clr_on_ack, input string name);
        exp_t            e, got;
        logic [NREG-1:0] exp_wen, exp_ren, prev_wen, prev_ren;
        logic [DW-1:0]   prev_di;
        logic [NREG-1:0] exp_clr;
        int              exp_n;
        bit              seen;
        exp_wen = '0;
        exp_ren = '0;
        if (a_addr < NREG) begin
            if (a_we) exp_wen = NREG'(1) << a_addr;
            else      exp_ren = NREG'(1) << a_addr;
        end
        e.rdata = (!a_we && a_addr < NREG) ? bank[a_addr] : '0;
        e.err   = (a_addr >= NREG);
        exp_n   = with_clr ? int'(NREG) + 3 : 2;
        prev_wen = '0;
        prev_ren = '0;
        prev_di  = '0;
        seen     = 1'b0;
        @(negedge clk);
        sb.push_back(e);
        req   = 1'b1;
        we    = a_we;
        addr  = a_addr;
        wdata = a_wdata;
        swclr = with_clr;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            swclr = 1'b0;
            if (with_clr && n <= int'(NREG)) begin
                exp_clr = NREG'(1) << (n - 1);
                checks++;
                if (clr !== exp_clr || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s sweep step %0d: clr=%b busy=%b expected clr=%b busy=1",
                             name, n, clr, busy, exp_clr);
                end
            end
            if (ack === 1'b1) begin
                seen = 1'b1;
                got  = sb.pop_front();
                checks++;
                if (n != exp_n) begin
                    errors++;
                    $display("FAIL %s latency: ack at cycle %0d expected %0d", name, n, exp_n);
                end
                checks++;
                if (rdata !== got.rdata) begin
                    errors++;
                    $display("FAIL %s rdata: got %h expected %h", name, rdata, got.rdata);
                end
`ifdef GPIO_CFG_CTRL_ERR_EN
                checks++;
                if (err !== got.err) begin
                    errors++;
                    $display("FAIL %s err: got %b expected %b", name, err, got.err);
                end
`endif
                checks++;
                if (prev_wen !== exp_wen || prev_ren !== exp_ren) begin
                    errors++;
                    $display("FAIL %s strobes: wen=%b ren=%b expected wen=%b ren=%b",
                             name, prev_wen, prev_ren, exp_wen, exp_ren);
                end
                if (exp_wen != '0) begin
                    checks++;
                    if (prev_di !== a_wdata) begin
                        errors++;
                        $display("FAIL %s di: got %h expected %h", name, prev_di, a_wdata);
                    end
                end
                req = 1'b0;
                if (clr_on_ack) swclr = 1'b1;
            end else begin
                checks++;
                if (wen != '0 && (ren != '0 || clr != '0) || (ren != '0 && clr != '0)) begin
                    errors++;
                    $display("FAIL %s exclusive strobes: wen=%b ren=%b clr=%b", name, wen, ren, clr);
                end
            end
            prev_wen = wen;
            prev_ren = ren;
            prev_di  = di;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no ack within 40 cycles", name);
            req = 1'b0;
            void'(sb.pop_front());
        end
        if (a_we && a_addr < NREG) bank[a_addr] = a_wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; swclr = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < int'(NREG); i++) bank[i] = DW'(8'h10 + i);
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, rdata, busy, wen, ren, di, clr} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0", {ack, rdata, busy, wen, ren, di, clr});
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_access(1'b1, 3'd2, 8'hA5, 1'b0, 1'b0, "write_a2");
        bank[5] = 8'h3C;
        do_access(1'b0, 3'd5, 8'h00, 1'b0, 1'b0, "read_a5");
    endtask

    task automatic test_clr_vs_req();
        do_access(1'b0, 3'd1, 8'h00, 1'b1, 1'b0, "clr_then_read");
    endtask

    task automatic test_clr_during_ack();
        logic [NREG-1:0] exp_clr;
        do_access(1'b1, 3'd0, 8'h5A, 1'b0, 1'b1, "write_clr_ack");
        @(negedge clk);
        swclr = 1'b0;
        checks++;
        if (busy !== 1'b1 || clr !== '0) begin
            errors++;
            $display("FAIL clr_ack pending: busy=%b clr=%b expected busy=1 clr=0", busy, clr);
        end
        for (int n = 0; n < int'(NREG); n++) begin
            @(negedge clk);
            // Extra pulse mid-sweep must merge into the running sweep.
            swclr = (n == 2);
            exp_clr = NREG'(1) << n;
            checks++;
            if (clr !== exp_clr || busy !== 1'b1) begin
                errors++;
                $display("FAIL clr_ack sweep %0d: clr=%b busy=%b expected clr=%b busy=1",
                         n, clr, busy, exp_clr);
            end
        end
        swclr = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (clr !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL clr_ack after: clr=%b busy=%b expected 0 0", clr, busy);
            end
        end
    endtask

    task automatic test_out_of_range();
        do_access(1'b0, 3'd7, 8'h00, 1'b0, 1'b0, "read_a7");
        do_access(1'b1, 3'd6, 8'hFF, 1'b0, 1'b0, "write_a6");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            do_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                      DW'($urandom), 1'b0, 1'b0, "b2b");
        end
    endtask

    task automatic test_rst_mid();
        bit found;
        found = 1'b0;
        @(negedge clk);
        swclr = 1'b1;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            swclr = 1'b0;
            if (clr === 6'b001000) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_sweep reach idx3: clr=%b expected 001000", clr);
        end
        rst = 1'b1;
        req = 1'b1; we = 1'b0; addr = 3'd4;
        @(negedge clk);
        checks++;
        if ({ack, rdata, busy, wen, ren, di, clr} !== '0) begin
            errors++;
            $display("FAIL rst_sweep outputs: got %h expected 0", {ack, rdata, busy, wen, ren, di, clr});
        end
        req = 1'b0;
        rst = 1'b0;
        // Reset in the middle of a CPU access must drop it without an ack.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 3'd3; wdata = 8'h77;
        @(negedge clk);
        checks++;
        if (wen !== 6'b001000) begin
            errors++;
            $display("FAIL rst_acc strobe: wen=%b expected 001000", wen);
        end
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({ack, busy, wen, ren, clr} !== '0) begin
                errors++;
                $display("FAIL rst_acc residual: ack=%b busy=%b wen=%b ren=%b clr=%b expected 0",
                         ack, busy, wen, ren, clr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_clr_vs_req();
        test_clr_during_ack();
        test_out_of_range();
        test_back_to_back();
        test_rst_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard residue: %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
